// File: rtl/dram_pkg.sv
// Shared DRAM front-end constants and the {write,addr} request word layout.
// Pure declarations: no latency, no flow control.
package dram_pkg;
  localparam int LOG_DRAM_SIZE = 6;
  localparam int PAGE_LEN      = 4;
  localparam int LOG_ADDR_SIZE = LOG_DRAM_SIZE - $clog2(PAGE_LEN);
  localparam int LOG_REQ_SIZE  = 1 + LOG_ADDR_SIZE;
  localparam int REQ_WRITE     = LOG_REQ_SIZE - 1;

  typedef logic [LOG_ADDR_SIZE-1:0] addr_t;
  typedef logic [PAGE_LEN-1:0]      page_t;

  typedef struct packed {
    logic  write;
    addr_t addr;
  } req_t;
endpackage

// File: rtl/dram_req_arbiter_if.sv
// Client and FIFO-side signals of the DRAM request arbiter.
// slave = arbiter side, master = clients plus FIFO models.
interface dram_req_arbiter_if;
  import dram_pkg::*;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0]                 req_write;
  logic [2*LOG_ADDR_SIZE-1:0] req_addr;
  logic [2*PAGE_LEN-1:0]      req_wdata;
  logic [1:0]                 rsp_valid;
  logic [1:0]                 rsp_ready;
  page_t                      rsp_data;
  logic                       frq_write_en;
  logic [LOG_REQ_SIZE-1:0]    frq_write_data;
  logic                       frq_full;
  logic                       fwd_write_en;
  page_t                      fwd_write_data;
  logic                       fwd_full;
  logic                       frd_read_en;
  page_t                      frd_read_data;
  logic                       frd_empty;
  logic                       error;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
           frq_full, fwd_full, frd_read_data, frd_empty,
    output req_ready, rsp_valid, rsp_data, frq_write_en, frq_write_data,
           fwd_write_en, fwd_write_data, frd_read_en, error
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
           frq_full, fwd_full, frd_read_data, frd_empty,
    input  req_ready, rsp_valid, rsp_data, frq_write_en, frq_write_data,
           fwd_write_en, fwd_write_data, frd_read_en, error
  );
endinterface

// File: rtl/dram_tag_queue.sv
// DEPTH x 1-bit circular FIFO of client ids for outstanding reads.
// Head is visible combinationally; push when full and pop when empty are ignored.
module dram_tag_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (PW+1)'(DEPTH));
    empty    = (count_q == '0);
    head     = mem_q[rd_ptr_q];
    count    = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/dram_req_arbiter.sv
// Two-client round-robin front end for the DRAM request/write-data FIFOs with in-order read return.
// Accept -> FIFO push one cycle later; a full FIFO holds the staged request and drops req_ready.
module dram_req_arbiter
  import dram_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  dram_req_arbiter_if.slave bus
);
  localparam int TW = $clog2(TAG_DEPTH);

  logic        out_valid_q, out_valid_d;
  req_t        out_req_q, out_req_d;
  page_t       out_wdata_q, out_wdata_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        error_q, error_d;

  logic        drain, space, gnt_vld, gnt_id;
  logic [1:0]  elig;
  req_t        gnt_req;
  page_t       gnt_wdata;
  logic        tag_push, tag_pop, tag_head, tag_full, tag_empty;
  logic [TW:0] tag_count;
  logic        rsp_act, stray;

  dram_tag_queue #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk     (clk),
    .rst     (rst),
    .push    (tag_push),
    .push_id (gnt_id),
    .pop     (tag_pop),
    .head    (tag_head),
    .count   (tag_count),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  always_comb begin
    // A write must fit in both FIFOs at once so it is never split.
    drain = out_valid_q & ~bus.frq_full & (~out_req_q.write | ~bus.fwd_full);
    space = ~out_valid_q | drain;
    elig  = '0;
    for (int i = 0; i < 2; i++)
      elig[i] = ~rst & bus.req_valid[i] & space &
                (bus.req_write[i] | (tag_count < (TW+1)'(TAG_DEPTH)));
    gnt_vld   = |elig;
    gnt_id    = (&elig) ? rr_ptr_q : elig[1];
    gnt_req   = '{write: (gnt_id ? bus.req_write[1] : bus.req_write[0]),
                  addr:  (gnt_id ? bus.req_addr[2*LOG_ADDR_SIZE-1:LOG_ADDR_SIZE]
                                 : bus.req_addr[LOG_ADDR_SIZE-1:0])};
    gnt_wdata = gnt_id ? bus.req_wdata[2*PAGE_LEN-1:PAGE_LEN] : bus.req_wdata[PAGE_LEN-1:0];
    tag_push  = gnt_vld & ~gnt_req.write & ~tag_full;

    bus.req_ready = '0;
    if (gnt_vld) bus.req_ready[gnt_id] = 1'b1;

    out_valid_d = out_valid_q;
    out_req_d   = out_req_q;
    out_wdata_d = out_wdata_q;
    if (gnt_vld) begin
      out_valid_d = 1'b1;
      out_req_d   = gnt_req;
      out_wdata_d = gnt_wdata;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    rr_ptr_d = gnt_vld ? ~gnt_id : rr_ptr_q;

    bus.frq_write_en   = drain;
    bus.frq_write_data = out_req_q;
    bus.fwd_write_en   = drain & out_req_q.write;
    bus.fwd_write_data = out_wdata_q;

    // Read data with no tag is unroutable: flag it and pop it so the FIFO cannot wedge.
    rsp_act = ~rst & ~bus.frd_empty & ~tag_empty;
    stray   = ~rst & ~bus.frd_empty & tag_empty;
    tag_pop = rsp_act & bus.rsp_ready[tag_head];
    bus.rsp_valid = '0;
    if (rsp_act) bus.rsp_valid[tag_head] = 1'b1;
    bus.rsp_data    = rsp_act ? bus.frd_read_data : '0;
    bus.frd_read_en = tag_pop | stray;
    error_d         = error_q | stray;
    bus.error       = error_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_req_q   <= '0;
      out_wdata_q <= '0;
      rr_ptr_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_req_q   <= out_req_d;
      out_wdata_q <= out_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      error_q     <= error_d;
    end
  end
endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: expected FIFO pushes and read responses are queued
// at stimulus time and popped by a monitor sampling just before each rising edge.
module tb_dram_req_arbiter;
  import dram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_req_arbiter_if ifc();
  dram_req_arbiter #(.TAG_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [LOG_REQ_SIZE-1:0] req;
    page_t                   wd;
  } frq_exp_t;

  frq_exp_t          exp_frq[$];
  logic [PAGE_LEN:0] exp_rsp[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    ifc.req_valid     = '0;
    ifc.req_write     = '0;
    ifc.req_addr      = '0;
    ifc.req_wdata     = '0;
    ifc.rsp_ready     = '0;
    ifc.frq_full      = 1'b0;
    ifc.fwd_full      = 1'b0;
    ifc.frd_read_data = '0;
    ifc.frd_empty     = 1'b1;
  endtask

  task automatic set_req(input int c, input logic v, input logic w, input addr_t a, input page_t d);
    ifc.req_valid[c] = v;
    ifc.req_write[c] = w;
    ifc.req_addr[c*LOG_ADDR_SIZE +: LOG_ADDR_SIZE] = a;
    ifc.req_wdata[c*PAGE_LEN +: PAGE_LEN] = d;
  endtask

  task automatic push_frq(input logic w, input addr_t a, input page_t d);
    frq_exp_t e;
    e.req = {w, a};
    e.wd  = d;
    exp_frq.push_back(e);
  endtask

  task automatic push_rsp(input logic c, input page_t d);
    exp_rsp.push_back({c, d});
  endtask

  task automatic reset_pulse();
    cyc(); idle();
    cyc();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
  endtask

  // Monitor: sample 1 time unit before the rising edge, i.e. what the DUT commits on.
  initial forever begin
    frq_exp_t          e;
    logic [PAGE_LEN:0] r;
    @(negedge clk);
    #4;
    if (!rst) begin
      chk("fwd_en_pairing", ifc.fwd_write_en, ifc.frq_write_en & ifc.frq_write_data[REQ_WRITE]);
      chk("rsp_onehot", ($countones(ifc.rsp_valid) <= 1), 1);
      if (ifc.frq_write_en) begin
        checks++;
        if (exp_frq.size() == 0) begin
          failures++;
          $display("FAIL frq_unexpected: got push %0h expected none", ifc.frq_write_data);
        end else begin
          e = exp_frq.pop_front();
          if (ifc.frq_write_data !== e.req) begin
            failures++;
            $display("FAIL frq_data: got %0h expected %0h", ifc.frq_write_data, e.req);
          end
          if (e.req[REQ_WRITE]) chk("fwd_data", ifc.fwd_write_data, e.wd);
        end
      end
      if (ifc.frd_read_en && ifc.rsp_valid != 2'b00) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected: got %0h expected none", {ifc.rsp_valid[1], ifc.rsp_data});
        end else begin
          r = exp_rsp.pop_front();
          if ({ifc.rsp_valid[1], ifc.rsp_data} !== r) begin
            failures++;
            $display("FAIL rsp_route: got %0h expected %0h", {ifc.rsp_valid[1], ifc.rsp_data}, r);
          end
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;

    // 1) reset with both clients valid
    set_req(0, 1'b1, 1'b0, 4'h3, 4'h0);
    set_req(1, 1'b1, 1'b0, 4'h4, 4'h0);
    ifc.frd_empty = 1'b0;
    cyc(); cyc(); #2;
    chk("rst_req_ready",   ifc.req_ready, 2'b00);
    chk("rst_frq_en",      ifc.frq_write_en, 1'b0);
    chk("rst_fwd_en",      ifc.fwd_write_en, 1'b0);
    chk("rst_rsp_valid",   ifc.rsp_valid, 2'b00);
    chk("rst_rsp_data",    ifc.rsp_data, 4'h0);
    chk("rst_frd_read_en", ifc.frd_read_en, 1'b0);
    chk("rst_error",       ifc.error, 1'b0);
    cyc(); ifc.frd_empty = 1'b1; rst = 1'b0; #2;
    chk("t1_first_grant", ifc.req_ready, 2'b01);
    push_frq(1'b0, 4'h3, 4'h0);
    cyc(); #2;
    chk("t1_second_grant", ifc.req_ready, 2'b10);
    push_frq(1'b0, 4'h4, 4'h0);
    reset_pulse();

    // 2) streaming reads alternate, then tag exhaustion (5)
    for (int k = 0; k < 4; k++) begin
      cyc();
      set_req(0, 1'b1, 1'b0, addr_t'(2*k),   4'h0);
      set_req(1, 1'b1, 1'b0, addr_t'(2*k+1), 4'h0);
      #2;
      chk("t2_alternate", ifc.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("t2_frq_every_cycle", ifc.frq_write_en, 1'b1);
      push_frq(1'b0, addr_t'(2*k + (k % 2)), 4'h0);
    end
    cyc();
    set_req(0, 1'b1, 1'b0, 4'h8, 4'h0);
    set_req(1, 1'b1, 1'b1, 4'h7, 4'h3);
    #2;
    chk("t5_tags_full_write_ok", ifc.req_ready, 2'b10);
    chk("t2_frq_every_cycle", ifc.frq_write_en, 1'b1);
    push_frq(1'b1, 4'h7, 4'h3);
    cyc();
    set_req(0, 1'b0, 1'b0, 4'h8, 4'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 4'h0);
    ifc.frd_empty = 1'b0; ifc.frd_read_data = 4'h6; ifc.rsp_ready = 2'b01;
    #2;
    chk("t5_pop_valid", ifc.rsp_valid, 2'b01);
    chk("t5_pop_rd_en", ifc.frd_read_en, 1'b1);
    push_rsp(1'b0, 4'h6);
    cyc();
    ifc.frd_empty = 1'b1; ifc.rsp_ready = 2'b00;
    set_req(0, 1'b1, 1'b0, 4'h8, 4'h0);
    #2;
    chk("t5_slot_freed", ifc.req_ready, 2'b01);
    push_frq(1'b0, 4'h8, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_req(0, 1'b0, 1'b0, 4'h0, 4'h0);
      ifc.frd_empty = 1'b0; ifc.frd_read_data = page_t'(10 + i); ifc.rsp_ready = 2'b11;
      push_rsp((i % 2 == 0), page_t'(10 + i));
    end
    cyc(); ifc.frd_empty = 1'b1; ifc.rsp_ready = 2'b00; #2;
    chk("t2_idle_rsp_data", ifc.rsp_data, 4'h0);
    chk("t2_idle_rsp_valid", ifc.rsp_valid, 2'b00);
    reset_pulse();

    // 3) write stalled by fwd_full
    cyc();
    set_req(1, 1'b1, 1'b1, 4'h5, 4'hA);
    ifc.fwd_full = 1'b1;
    #2;
    chk("t3_accept", ifc.req_ready, 2'b10);
    push_frq(1'b1, 4'h5, 4'hA);
    for (int k = 0; k < 3; k++) begin
      cyc();
      set_req(1, 1'b1, 1'b1, 4'h6, 4'hB);
      #2;
      chk("t3_stall_ready", ifc.req_ready, 2'b00);
      chk("t3_stall_frq",   ifc.frq_write_en, 1'b0);
      chk("t3_stall_fwd",   ifc.fwd_write_en, 1'b0);
    end
    cyc(); ifc.fwd_full = 1'b0; #2;
    chk("t3_release_push", {ifc.frq_write_en, ifc.fwd_write_en}, 2'b11);
    chk("t3_release_ready", ifc.req_ready, 2'b10);
    push_frq(1'b1, 4'h6, 4'hB);
    cyc(); set_req(1, 1'b0, 1'b0, 4'h0, 4'h0);
    reset_pulse();

    // 4) in-order read return with a stalled client
    cyc(); set_req(0, 1'b1, 1'b0, 4'h1, 4'h0); #2;
    chk("t4_grant_c0", ifc.req_ready, 2'b01); push_frq(1'b0, 4'h1, 4'h0);
    cyc(); set_req(0, 1'b0, 1'b0, 4'h0, 4'h0); set_req(1, 1'b1, 1'b0, 4'h2, 4'h0); #2;
    chk("t4_grant_c1", ifc.req_ready, 2'b10); push_frq(1'b0, 4'h2, 4'h0);
    cyc(); set_req(1, 1'b0, 1'b0, 4'h0, 4'h0); set_req(0, 1'b1, 1'b0, 4'h3, 4'h0); #2;
    chk("t4_grant_c0b", ifc.req_ready, 2'b01); push_frq(1'b0, 4'h3, 4'h0);
    cyc(); set_req(0, 1'b0, 1'b0, 4'h0, 4'h0);
    ifc.frd_empty = 1'b0; ifc.frd_read_data = 4'h7; ifc.rsp_ready = 2'b01; #2;
    chk("t4_rsp0_valid", ifc.rsp_valid, 2'b01); push_rsp(1'b0, 4'h7);
    cyc(); ifc.frd_read_data = 4'h8; ifc.rsp_ready = 2'b01; #2;
    chk("t4_stall_valid", ifc.rsp_valid, 2'b10);
    chk("t4_stall_rd_en", ifc.frd_read_en, 1'b0);
    chk("t4_stall_data",  ifc.rsp_data, 4'h8);
    cyc(); ifc.rsp_ready = 2'b10; #2;
    chk("t4_rsp1_rd_en", ifc.frd_read_en, 1'b1); push_rsp(1'b1, 4'h8);
    cyc(); ifc.frd_read_data = 4'h9; ifc.rsp_ready = 2'b01; push_rsp(1'b0, 4'h9);
    cyc(); ifc.frd_empty = 1'b1; ifc.rsp_ready = 2'b00;
    reset_pulse();

    // 6) stray read data, then reset mid-burst
    cyc(); ifc.frd_empty = 1'b0; ifc.frd_read_data = 4'h5; #2;
    chk("t6_discard_rd_en", ifc.frd_read_en, 1'b1);
    chk("t6_discard_valid", ifc.rsp_valid, 2'b00);
    chk("t6_discard_data",  ifc.rsp_data, 4'h0);
    chk("t6_error_before",  ifc.error, 1'b0);
    cyc(); ifc.frd_empty = 1'b1; #2;
    chk("t6_error_set", ifc.error, 1'b1);
    cyc(); set_req(0, 1'b1, 1'b0, 4'h2, 4'h0); #2;
    chk("t6_error_sticky", ifc.error, 1'b1);
    chk("t6_burst_grant0", ifc.req_ready, 2'b01);
    push_frq(1'b0, 4'h2, 4'h0);
    cyc(); set_req(0, 1'b1, 1'b0, 4'h3, 4'h0); #2;
    chk("t6_burst_grant1", ifc.req_ready, 2'b01);
    cyc(); rst = 1'b1; #2;
    chk("t6_rst_ready", ifc.req_ready, 2'b00);
    chk("t6_rst_frq",   ifc.frq_write_en, 1'b0);
    cyc(); rst = 1'b0; set_req(0, 1'b0, 1'b0, 4'h0, 4'h0); #2;
    chk("t6_error_cleared", ifc.error, 1'b0);
    chk("t6_no_stale_push", ifc.frq_write_en, 1'b0);
    cyc(); ifc.frd_empty = 1'b0; ifc.frd_read_data = 4'h9; ifc.rsp_ready = 2'b11; #2;
    chk("t6_tags_cleared_valid", ifc.rsp_valid, 2'b00);
    chk("t6_tags_cleared_rd_en", ifc.frd_read_en, 1'b1);
    cyc(); ifc.frd_empty = 1'b1; ifc.rsp_ready = 2'b00;

    cyc(); cyc(); #2;
    chk("frq_queue_drained", exp_frq.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
